// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with a small byte FIFO in front of it.
//               Bytes enter through a valid/ready port and are sent as 8N1
//               frames (start 0, 8 data bits LSB first, stop 1). Queued
//               bytes go out back-to-back with no idle bits between frames.
//               Optional feature macro: UART_TX_PARITY_EN. When defined, an
//               even-parity bit is inserted between the data and stop bits
//               (8E1, 11-bit frame).
// Parameters  : FIFO_DEPTH   - byte FIFO entries (power of two, >= 2)
//               CLKS_PER_BIT - clk cycles per UART bit (>= 1)
// Ports       : clk        - clock, all logic on posedge
//               rst        - synchronous active-high reset
//               in_data    - byte to transmit
//               in_valid   - in_data valid
//               in_ready   - FIFO can accept (transfer = in_valid & in_ready)
//               tx         - UART serial line, idle high, registered
//               busy       - frame in progress or FIFO non-empty
//               fifo_count - bytes waiting in the FIFO (excludes byte on line)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_tmr_w  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    state_t              r_state;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_tx;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic               w_tick;
    logic [7:0]         w_head;
    state_t             w_state_next;
    logic [7:0]         w_shift_next;
    logic [2:0]         w_bit_next;
    logic [c_tmr_w-1:0] w_tmr_next;
    logic               w_tx_next;

    // No bypass: a full FIFO refuses a byte even when a pop happens the same
    // cycle. in_ready is also forced low while reset is asserted.
    assign in_ready    = ~rst & (r_count < c_depth);
    assign w_push      = in_valid & in_ready;
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tick      = (r_timer == c_tmr_last);

    assign tx          = r_tx;
    assign busy        = (r_state != S_IDLE) | w_not_empty;
    assign fifo_count  = r_count;

    // ------------------------------------------------------------------------
    // Next-state / datapath logic. w_tx_next is the line value for the state
    // being entered, so tx leaves a register and changes on the same edge as
    // the state.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_idx;
        w_tx_next    = 1'b1;
        w_tmr_next   = w_tick ? '0 : r_timer + 1'b1;

        case (r_state)
            S_IDLE: begin
                w_tmr_next = '0;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_bit_next   = 3'd0;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                w_tx_next = 1'b0;
                if (w_tick) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end
            end

            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_next   = r_bit_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_tick) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    // Chain straight into the next start bit when a byte is
                    // waiting, so queued frames leave with no idle gap.
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_bit_next   = 3'd0;
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tmr_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM and shifter state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_timer   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_next;
            r_timer   <= w_tmr_next;
            r_tx      <= w_tx_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shifter discards bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers wrap naturally since the depth is
    // a power of two. A pop only occurs when non-empty, and a push only when
    // not full, so the count never leaves 0..FIFO_DEPTH.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire
